// File: rtl/d_cache_controller_if.sv
// rtl/d_cache_controller_if.sv - arbiter/controller bus of the direct-mapped data cache
// master = arbiter side, slave = cache controller side.
interface d_cache_controller_if #(
   parameter int LINE_BITS = 1024
);
   logic                   raddr_valid;
   logic [31:0]            raddr;
   logic                   rdata_valid;
   logic [31:0]            rdata;
   logic                   waddr_valid;
   logic [31:0]            waddr;
   logic [LINE_BITS-1:0]   wdata;
   logic [LINE_BITS/8-1:0] wmask;
   logic                   sent_repair;
   logic                   repair_resolved;
   logic                   read_repair_request;
   logic [31:0]            missed_addr;
   logic                   busy;

   modport master (
      output raddr_valid, raddr, waddr_valid, waddr, wdata, wmask,
             sent_repair, repair_resolved,
      input  rdata_valid, rdata, read_repair_request, missed_addr, busy
   );

   modport slave (
      input  raddr_valid, raddr, waddr_valid, waddr, wdata, wmask,
             sent_repair, repair_resolved,
      output rdata_valid, rdata, read_repair_request, missed_addr, busy
   );
endinterface

// File: rtl/d_cache_controller.sv
// rtl/d_cache_controller.sv - direct-mapped data-cache controller
// Word reads, byte-masked line stores, miss repair via the arbiter and read replay.
module d_cache_controller #(
   parameter int NUM_SETS  = 64,
   parameter int LINE_BITS = 1024
) (
   input logic                 clk,
   input logic                 rst,
   d_cache_controller_if.slave bus
);
   localparam int BYTES    = LINE_BITS / 8;
   localparam int OFF_BITS = $clog2(BYTES);
   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - OFF_BITS - IDX_BITS;
   localparam int LSB_BITS = $clog2(LINE_BITS);

   typedef enum logic [2:0] {IDLE, LOOKUP, MISS, RESOLVE, REPLAY} state_t;
   state_t state, next_state;

   logic [NUM_SETS-1:0]  valid;
   logic [TAG_BITS-1:0]  tags  [NUM_SETS];
   logic [LINE_BITS-1:0] lines [NUM_SETS];

   logic [31:0] req_addr;
   logic        rdata_valid_q, repair_req_q, busy_q;
   logic [31:0] rdata_q, missed_addr_q;

   logic        rdata_valid_d, repair_req_d, req_load, line_we, tag_we;
   logic [31:0] rdata_d, missed_addr_d;

   logic [IDX_BITS-1:0]  req_idx, wr_idx;
   logic [TAG_BITS-1:0]  req_tag, wr_tag;
   logic                 lookup_hit, store_hit;
   logic [LINE_BITS-1:0] req_line, wr_line, merged_line;
   logic [LSB_BITS-1:0]  word_lsb;
   logic [31:0]          req_word;
   logic                 unused_waddr_bits;

   assign req_idx  = req_addr[OFF_BITS +: IDX_BITS];
   assign req_tag  = req_addr[31 -: TAG_BITS];
   assign wr_idx   = bus.waddr[OFF_BITS +: IDX_BITS];
   assign wr_tag   = bus.waddr[31 -: TAG_BITS];
   assign unused_waddr_bits = ^bus.waddr[OFF_BITS-1:0];

   assign req_line   = lines[req_idx];
   assign wr_line    = lines[wr_idx];
   assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);
   assign store_hit  = valid[wr_idx] && (tags[wr_idx] == wr_tag);
   assign word_lsb   = {req_addr[OFF_BITS-1:2], 5'd0};
   assign req_word   = req_line[word_lsb +: 32];

   // Stores and repair fills share one byte-merge path into the write-indexed set.
   always_comb begin
      merged_line = wr_line;
      for (int b = 0; b < BYTES; b++) begin
         if (bus.wmask[b]) merged_line[8*b +: 8] = bus.wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state    = state;
      rdata_valid_d = 1'b0;
      rdata_d       = rdata_q;
      repair_req_d  = repair_req_q;
      missed_addr_d = missed_addr_q;
      req_load      = 1'b0;
      line_we       = 1'b0;
      tag_we        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.waddr_valid && store_hit) line_we = 1'b1;
            if (bus.raddr_valid) begin
               req_load   = 1'b1;
               next_state = LOOKUP;
            end
         end
         LOOKUP, REPLAY: begin
            if (lookup_hit) begin
               rdata_valid_d = 1'b1;
               rdata_d       = req_word;
               next_state    = IDLE;
            end else begin
               repair_req_d  = 1'b1;
               missed_addr_d = req_addr;
               next_state    = MISS;
            end
         end
         MISS: begin
            if (bus.sent_repair && bus.waddr_valid) begin
               line_we      = 1'b1;
               tag_we       = 1'b1;
               repair_req_d = 1'b0;
               next_state   = RESOLVE;
            end
         end
         RESOLVE: begin
            if (bus.repair_resolved) next_state = REPLAY;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr      <= 32'd0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= 32'd0;
         repair_req_q  <= 1'b0;
         missed_addr_q <= 32'd0;
         busy_q        <= 1'b0;
      end else begin
         if (req_load) req_addr <= bus.raddr;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         repair_req_q  <= repair_req_d;
         missed_addr_q <= missed_addr_d;
         busy_q        <= (next_state != IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         valid         <= '0;
      else if (tag_we) valid[wr_idx] <= 1'b1;
   end

   // Line and tag arrays carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (line_we) lines[wr_idx] <= merged_line;
      if (tag_we)  tags[wr_idx]  <= wr_tag;
   end

   assign bus.rdata_valid         = rdata_valid_q;
   assign bus.rdata               = rdata_q;
   assign bus.read_repair_request = repair_req_q;
   assign bus.missed_addr         = missed_addr_q;
   assign bus.busy                = busy_q;
endmodule

// File: tb/tb_d_cache_controller.sv
// tb/tb_d_cache_controller.sv - randomized bench for d_cache_controller
// Cache contents are modelled as plain per-set arrays updated by address arithmetic.
module tb_d_cache_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   d_cache_controller_if bus ();
   d_cache_controller dut (.clk(clk), .rst(rst), .bus(bus));

   logic [1023:0] m_line  [64];
   logic [18:0]   m_tag   [64];
   bit            m_valid [64];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 7) % 64);
   endfunction

   function automatic logic [18:0] tag_of(input logic [31:0] a);
      return 19'(a >> 13);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] a);
      logic [1023:0] l;
      l = m_line[idx_of(a)];
      return 32'(l >> (32 * ((a % 128) / 4)));
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [1023:0] d,
                          input logic [127:0] m, input bit fill);
      for (int b = 0; b < 128; b++)
         if (m[b]) m_line[idx_of(a)][8*b +: 8] = d[8*b +: 8];
      if (fill) begin
         m_tag[idx_of(a)]   = tag_of(a);
         m_valid[idx_of(a)] = 1'b1;
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.raddr_valid = 0; bus.raddr = '0; bus.waddr_valid = 0; bus.waddr = '0;
      bus.wdata = '0; bus.wmask = '0; bus.sent_repair = 0; bus.repair_resolved = 0;
   endtask

   function automatic logic [1023:0] rand_line();
      logic [1023:0] d;
      for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [1023:0] pattern_line();
      logic [1023:0] d;
      for (int i = 0; i < 32; i++) d[32*i +: 32] = {8{4'(7 - (i % 8))}};
      return d;
   endfunction

   // Entered at posedge+1; returns at posedge+1 with the DUT idle.
   task automatic do_store(input logic [31:0] a, input logic [1023:0] d, input logic [127:0] m);
      bus.waddr_valid = 1; bus.waddr = a; bus.wdata = d; bus.wmask = m;
      @(posedge clk); #1;
      idle_inputs();
      if (m_hit(a)) m_write(a, d, m, 0);
   endtask

   // Entered at negedge with the DUT in MISS; returns at negedge after the replayed hit.
   task automatic repair(input logic [31:0] a, input bit directed);
      bit done = 0;
      int attempts = 0;
      logic [31:0] fa;
      logic [1023:0] d;
      while (!done && attempts < 4) begin
         @(posedge clk); #1;
         if (!directed) begin
            repeat ($urandom_range(0, 2)) begin
               bus.repair_resolved = 1'($urandom % 2);
               @(negedge clk);
               check("miss_hold_req", bus.read_repair_request, 1);
               check("miss_hold_addr", bus.missed_addr, a);
               @(posedge clk); #1;
               bus.repair_resolved = 0;
            end
         end
         fa = a;
         if (!directed && attempts == 0 && ($urandom % 3 == 0))
            fa = a ^ (32'd1 << $urandom_range(7, 31));
         d = directed ? pattern_line() : rand_line();
         bus.sent_repair = 1; bus.waddr_valid = 1; bus.waddr = fa;
         bus.wdata = d; bus.wmask = '1;
         @(posedge clk); #1;
         idle_inputs();
         m_write(fa, d, '1, 1);
         @(negedge clk);
         check("fill_req_drop", bus.read_repair_request, 0);
         check("fill_busy", bus.busy, 1);
         @(posedge clk); #1;
         if (!directed) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         bus.repair_resolved = 1;
         @(posedge clk); #1;
         bus.repair_resolved = 0;
         @(posedge clk);
         @(negedge clk);
         if (m_hit(a)) begin
            check("replay_valid", bus.rdata_valid, 1);
            check("replay_data", bus.rdata, m_word(a));
            done = 1;
         end else begin
            check("replay_rereq", bus.read_repair_request, 1);
            check("replay_addr", bus.missed_addr, a);
            check("replay_novalid", bus.rdata_valid, 0);
         end
         attempts++;
      end
      if (!done) check("repair_bound", 0, 1);
   endtask

   // Entered at posedge+1; returns at posedge+1 with the DUT idle.
   task automatic do_read(input logic [31:0] a, input bit directed, input bit with_store,
                          input logic [31:0] sa, input logic [1023:0] sd, input logic [127:0] sm);
      bus.raddr_valid = 1; bus.raddr = a;
      if (with_store) begin
         bus.waddr_valid = 1; bus.waddr = sa; bus.wdata = sd; bus.wmask = sm;
      end
      @(posedge clk); #1;
      idle_inputs();
      if (with_store && m_hit(sa)) m_write(sa, sd, sm, 0);
      @(posedge clk);
      @(negedge clk);
      if (m_hit(a)) begin
         check("hit_valid", bus.rdata_valid, 1);
         check("hit_data", bus.rdata, m_word(a));
         check("hit_noreq", bus.read_repair_request, 0);
      end else begin
         check("miss_req", bus.read_repair_request, 1);
         check("miss_addr", bus.missed_addr, a);
         check("miss_novalid", bus.rdata_valid, 0);
         check("miss_busy", bus.busy, 1);
         repair(a, directed);
      end
      @(posedge clk); #1;
      check("idle_after_read", bus.busy, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [18:0] tags [3];
      logic [5:0]  sets [4];
      tags[0] = 19'h555DE; tags[1] = 19'h00001; tags[2] = 19'h7FFFF;
      sets[0] = 6'd25; sets[1] = 6'd0; sets[2] = 6'd63; sets[3] = 6'd7;
      return {tags[$urandom % 3], sets[$urandom % 4], 7'($urandom)};
   endfunction

   initial begin
      logic [1023:0] sd;
      logic [127:0]  sm;
      idle_inputs();
      rst = 1;
      m_reset();
      #1;
      check("rst_valid", bus.rdata_valid, 0);
      check("rst_req", bus.read_repair_request, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_missed", bus.missed_addr, 0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      do_read(32'hAABB_CCDD, 1, 0, '0, '0, '0);
      check("tp_word23", bus.rdata, 32'h0000_0000);
      check("tp_set25_tag", {13'd0, m_tag[25]}, 32'h0005_55DE);
      do_read(32'hAABB_CCDD, 1, 0, '0, '0, '0);
      check("tp_rehit", bus.rdata, 32'h0000_0000);
      do_read(32'hAABB_CC94, 1, 0, '0, '0, '0);
      check("tp_word5", bus.rdata, 32'h2222_2222);
      sd = 1024'(32'hDEAD_BEEF) << 160;
      sm = 128'hF << 20;
      do_store(32'hAABB_CC94, sd, sm);
      do_read(32'hAABB_CC94, 1, 0, '0, '0, '0);
      check("tp_store", bus.rdata, 32'hDEAD_BEEF);
      do_store(32'hAABB_EC94, 1024'(32'h1111_1111) << 160, sm);
      do_read(32'hAABB_CC94, 1, 0, '0, '0, '0);
      check("tp_store_drop", bus.rdata, 32'hDEAD_BEEF);

      bus.raddr_valid = 1; bus.raddr = 32'hAABB_EC94;
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      check("rstmiss_req", bus.read_repair_request, 1);
      rst = 1;
      #1;
      check("rstmiss_req_drop", bus.read_repair_request, 0);
      check("rstmiss_busy_drop", bus.busy, 0);
      m_reset();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      do_read(32'hAABB_CCDD, 1, 0, '0, '0, '0);
      check("tp_after_rst", bus.rdata, 32'h0000_0000);

      for (int it = 0; it < 80; it++) begin
         case ($urandom % 3)
            0: do_store(rand_addr(), rand_line(), {$urandom, $urandom, $urandom, $urandom});
            1: do_read(rand_addr(), 0, 0, '0, '0, '0);
            default: do_read(rand_addr(), 0, 1, rand_addr(), rand_line(),
                             {$urandom, $urandom, $urandom, $urandom});
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
